shake_arbiter: RTL and testbench

Round-robin arbiter that shares one SHAKE core among several key-generation requesters (seed expansion, secret-vector sampling, public-key hashing). It queues competing hash jobs and drives the core's `rtr`/`rts` handshake. It holds the granted requester's input stable for the whole job, then captures the digest into a result register. Each job ends with a one-cycle `done` pulse to its owner.

---
 rtl/shake_arbiter_if.sv | 28 ++
 rtl/shake_arbiter.sv | 121 ++++++++++++
 tb/tb_shake_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shake_arbiter_if.sv
// shake_arbiter_if: requester-side and core-side signals of the arbiter.
// master: arbiter side, slave: requesters plus core side.
interface shake_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int len    = 512,
    parameter int outlen = 511
);
    logic [NREQ-1:0]     req;
    logic [NREQ*len-1:0] req_data;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [outlen:0]     dout;
    logic                busy;
    logic [len-1:0]      core_din;
    logic                core_rtr;
    logic                core_rts;
    logic [outlen:0]     core_dout;

    modport master (
        input  req, req_data, core_rts, core_dout,
        output gnt, done, dout, busy, core_din, core_rtr
    );

    modport slave (
        output req, req_data, core_rts, core_dout,
        input  gnt, done, dout, busy, core_din, core_rtr
    );
endinterface

// File: rtl/shake_arbiter.sv
// shake_arbiter: round-robin sharing of one SHAKE core among requesters.
// Latches the winner's message, runs the rtr/rts job, captures the digest.
module shake_arbiter #(
    parameter int NREQ   = 4,
    parameter int len    = 512,
    parameter int outlen = 511
) (
    input logic            clk,
    input logic            reset,
    shake_arbiter_if.master bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [outlen:0] dout_q, dout_d;
    logic [len-1:0]  din_q, din_d;
    logic            rtr_q, rtr_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   pick;

    // first active request after the previous winner, wrapping
    always_comb begin
        logic found;
        int   idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    // job sequencing: grant, wait for result, wait for core idle, pulse done
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        dout_d  = dout_q;
        din_d   = din_q;
        rtr_d   = rtr_q;
        last_d  = last_q;
        win_d   = win_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req && !bus.core_rts) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    din_d       = bus.req_data[int'(pick)*len +: len];
                    rtr_d       = 1'b1;
                    win_d       = pick;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (bus.core_rts) begin
                    dout_d  = bus.core_dout;
                    rtr_d   = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!bus.core_rts) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    last_d  = win_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            dout_q  <= '0;
            din_q   <= '0;
            rtr_q   <= 1'b0;
            last_q  <= IW'(NREQ - 1);
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            din_q   <= din_d;
            rtr_q   <= rtr_d;
            last_q  <= last_d;
            win_q   <= win_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.dout     = dout_q;
    assign bus.core_din = din_q;
    assign bus.core_rtr = rtr_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_shake_arbiter.sv
// tb_shake_arbiter: directed checks of shake_arbiter against a
// behavioural SHAKE core (rts 10 cycles after rtr, dout = {N,N}^const).
module tb_shake_arbiter;
    localparam int NREQ   = 4;
    localparam int LEN    = 512;
    localparam int OUTLEN = 511;

    localparam logic [511:0] KEY = {8{64'h0123_4567_89AB_CDEF}};
    localparam logic [511:0] D0  = {16{32'h1111_0A0A}};
    localparam logic [511:0] D1  = {16{32'h2222_0B0B}};
    localparam logic [511:0] D2  = {16{32'h3333_0C0C}};
    localparam logic [511:0] D3  = {16{32'h4444_0D0D}};
    localparam logic [511:0] DA  = {16{32'hDEAD_BEEF}};
    localparam logic [511:0] DB  = {16{32'hFACE_F00D}};
    localparam logic [511:0] DE  = {16{32'h5A5A_C3C3}};

    logic clk;
    logic reset;
    logic mrst_n;
    logic stick;
    int   n_tests;
    int   n_fail;

    shake_arbiter_if #(.NREQ(NREQ), .len(LEN), .outlen(OUTLEN)) bus ();

    shake_arbiter #(.NREQ(NREQ), .len(LEN), .outlen(OUTLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    mph;
    logic [3:0]    mcnt;
    logic [1023:0] mdd;

    assign mdd           = {bus.core_din, bus.core_din} ^ {KEY, KEY};
    assign bus.core_dout = mdd[511:0];

    // behavioural core handshake
    always_ff @(posedge clk or negedge mrst_n) begin
        if (!mrst_n) begin
            mph          <= 2'd0;
            mcnt         <= 4'd0;
            bus.core_rts <= 1'b0;
        end else begin
            case (mph)
                2'd0: if (bus.core_rtr) begin
                    mph  <= 2'd1;
                    mcnt <= 4'd0;
                end
                2'd1: if (mcnt == 4'd9) begin
                    bus.core_rts <= 1'b1;
                    mph          <= 2'd2;
                end else begin
                    mcnt <= mcnt + 4'd1;
                end
                2'd2: if (!bus.core_rtr && !stick) begin
                    bus.core_rts <= 1'b0;
                    mph          <= 2'd0;
                end
                default: mph <= 2'd0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [511:0] v);
        bus.req_data[i*LEN +: LEN] = v;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        mrst_n = 1'b0;
        tick();
        reset  = 1'b1;
        mrst_n = 1'b1;
        tick();
    endtask

    task automatic wait_gnt();
        int n;
        n = 0;
        while (bus.gnt == '0 && n < 40) begin
            tick();
            n++;
        end
        check("gnt_seen", 512'(|bus.gnt), 512'(1));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (bus.done == '0 && n < 40) begin
            tick();
            n++;
        end
        check("done_seen", 512'(|bus.done), 512'(1));
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        stick        = 1'b0;
        reset        = 1'b0;
        mrst_n       = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 512'(bus.gnt), 512'(0));
        check("rst_done", 512'(bus.done), 512'(0));
        check("rst_dout", bus.dout, 512'(0));
        check("rst_din", bus.core_din, 512'(0));
        check("rst_rtr", 512'(bus.core_rtr), 512'(0));
        check("rst_busy", 512'(bus.busy), 512'(0));
        reset  = 1'b1;
        mrst_n = 1'b1;
        tick();

        // single request
        set_data(0, D0);
        bus.req = 4'b0001;
        tick();
        check("s_gnt", 512'(bus.gnt), 512'(4'b0001));
        check("s_rtr", 512'(bus.core_rtr), 512'(1));
        check("s_din", bus.core_din, D0);
        check("s_busy", 512'(bus.busy), 512'(1));
        wait_done();
        check("s_done", 512'(bus.done), 512'(4'b0001));
        check("s_dout", bus.dout, D0 ^ KEY);
        bus.req = '0;
        tick();
        check("s_idle", 512'(bus.busy), 512'(0));
        check("s_pulse", 512'(bus.done), 512'(0));

        // contention from reset: 0,1,2,3
        do_reset();
        set_data(0, D0);
        set_data(1, D1);
        set_data(2, D2);
        set_data(3, D3);
        bus.req = 4'b1111;
        tick();
        for (int i = 0; i < 4; i++) begin
            logic [511:0] dv;
            dv = (i == 0) ? D0 : (i == 1) ? D1 : (i == 2) ? D2 : D3;
            check("rr_gnt", 512'(bus.gnt), 512'(1) << i);
            wait_done();
            check("rr_done", 512'(bus.done), 512'(1) << i);
            check("rr_dout", bus.dout, dv ^ KEY);
            bus.req[i] = 1'b0;
            tick();
            check("rr_gap", 512'(bus.gnt), 512'(0));
            if (i < 3) tick();
        end

        // fairness: 1 held, 2 re-requests after each done
        bus.req = 4'b0110;
        for (int j = 0; j < 4; j++) begin
            logic [3:0] ex;
            ex = (j % 2 == 0) ? 4'b0010 : 4'b0100;
            wait_gnt();
            check("fair_gnt", 512'(bus.gnt), 512'(ex));
            wait_done();
            check("fair_done", 512'(bus.done), 512'(ex));
            if (ex == 4'b0100) begin
                bus.req[2] = 1'b0;
                tick();
                bus.req[2] = 1'b1;
            end
        end
        bus.req = '0;
        repeat (2) tick();

        // abandon: req dropped during RUN
        set_data(3, D3);
        bus.req = 4'b1000;
        wait_gnt();
        check("ab_gnt", 512'(bus.gnt), 512'(4'b1000));
        repeat (2) tick();
        bus.req = '0;
        wait_done();
        check("ab_done", 512'(bus.done), 512'(4'b1000));
        check("ab_dout", bus.dout, D3 ^ KEY);
        repeat (2) tick();

        // data isolation
        set_data(0, DA);
        bus.req = 4'b0001;
        wait_gnt();
        check("iso_gnt", 512'(bus.gnt), 512'(4'b0001));
        set_data(0, DB);
        repeat (3) tick();
        check("iso_din", bus.core_din, DA);
        wait_done();
        check("iso_dout", bus.dout, DA ^ KEY);
        bus.req = '0;
        repeat (2) tick();

        // reset mid-RUN with core stuck at rts=1
        set_data(0, DE);
        bus.req = 4'b0001;
        stick   = 1'b1;
        wait_gnt();
        begin
            int n;
            n = 0;
            while (!bus.core_rts && n < 30) begin
                tick();
                n++;
            end
        end
        check("mr_rts", 512'(bus.core_rts), 512'(1));
        check("mr_busy0", 512'(bus.busy), 512'(1));
        reset = 1'b0;
        #1;
        check("mr_gnt", 512'(bus.gnt), 512'(0));
        check("mr_rtr", 512'(bus.core_rtr), 512'(0));
        check("mr_dout", bus.dout, 512'(0));
        check("mr_done", 512'(bus.done), 512'(0));
        check("mr_busy", 512'(bus.busy), 512'(0));
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check("mr_hold", 512'(bus.gnt), 512'(0));
        check("mr_idle", 512'(bus.busy), 512'(0));
        stick = 1'b0;
        tick();
        check("mr_rts0", 512'(bus.core_rts), 512'(0));
        check("mr_nogt", 512'(bus.gnt), 512'(0));
        tick();
        check("mr_gnt1", 512'(bus.gnt), 512'(4'b0001));
        check("mr_din", bus.core_din, DE);
        wait_done();
        check("mr_dout1", bus.dout, DE ^ KEY);
        bus.req = '0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
